// File: rtl/status_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : status_pkg
// Purpose  : Shared definitions for the 6502 processor status register (P):
//            flag command encoding, bit positions and the reset value.
// Revision : 1.0 - initial release
// ============================================================================
package status_pkg;

  // One flag command per cycle, issued alongside flag_en
  typedef enum logic [3:0] {
    FOP_NOP       = 4'd0,
    FOP_NZ        = 4'd1,
    FOP_NZC       = 4'd2,
    FOP_NZCV      = 4'd3,
    FOP_NZ_BUS    = 4'd4,
    FOP_BIT       = 4'd5,
    FOP_PLP       = 4'd6,
    FOP_CLC       = 4'd7,
    FOP_SEC       = 4'd8,
    FOP_CLI       = 4'd9,
    FOP_SEI       = 4'd10,
    FOP_CLD       = 4'd11,
    FOP_SED       = 4'd12,
    FOP_CLV       = 4'd13,
    FOP_IRQ_ENTRY = 4'd14,
    FOP_RSVD      = 4'd15
  } flag_op_e;

  // Bit positions inside the P byte
  localparam int P_N = 7;
  localparam int P_V = 6;
  localparam int P_U = 5;
  localparam int P_B = 4;
  localparam int P_D = 3;
  localparam int P_I = 2;
  localparam int P_Z = 1;
  localparam int P_C = 0;

  // P as seen on the stack after reset with default parameters (I=1, D=0, B=0)
  localparam logic [7:0] P_RESET = 8'h24;

  // Assemble the pushable P byte; bit 5 always reads as 1
  function automatic logic [7:0] make_p(input logic n, input logic v,
                                        input logic b, input logic d,
                                        input logic i, input logic z,
                                        input logic c);
    logic [7:0] p;
    p      = 8'h00;
    p[P_N] = n;
    p[P_V] = v;
    p[P_U] = 1'b1;
    p[P_B] = b;
    p[P_D] = d;
    p[P_I] = i;
    p[P_Z] = z;
    p[P_C] = c;
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/status_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : status_reg_if
// Purpose  : Bundle between the controller/ALU side and the status register.
//            master = controller/ALU side, slave = status register.
// Revision : 1.0 - initial release
// ============================================================================
interface status_reg_if;
  import status_pkg::*;

  logic       flag_en;
  flag_op_e   flag_op;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_overflow;
  logic [7:0] bus_in;
  logic       push_brk;

  logic [7:0] p_out;
  logic       carry_flag;
  logic       decimal_flag;
  logic       zero_flag;
  logic       negative_flag;
  logic       overflow_flag;
  logic       irq_inhibit;

  modport master (
    output flag_en, flag_op, alu_result, alu_carry, alu_overflow, bus_in, push_brk,
    input  p_out, carry_flag, decimal_flag, zero_flag, negative_flag,
           overflow_flag, irq_inhibit
  );

  modport slave (
    input  flag_en, flag_op, alu_result, alu_carry, alu_overflow, bus_in, push_brk,
    output p_out, carry_flag, decimal_flag, zero_flag, negative_flag,
           overflow_flag, irq_inhibit
  );

endinterface
`default_nettype wire

// File: rtl/status_reg.sv
`default_nettype none
// ============================================================================
// Module   : status_reg
// Purpose  : 6502 status register P. Six stored flags (N V D I Z C) updated by
//            one flag command per enabled cycle; B is supplied live at push
//            time and bit 5 is hard-wired to 1. irq_inhibit lags I by one
//            clock to reproduce the CLI/SEI one-instruction latency.
// Revision : 1.0 - initial release
// ============================================================================
module status_reg
  import status_pkg::*;
#(
  parameter bit RESET_I = 1'b1,
  parameter bit RESET_D = 1'b0
) (
  input  wire logic   clk,
  input  wire logic   rst,
  status_reg_if.slave sif
);

  logic r_n, r_v, r_d, r_i, r_z, r_c;
  logic r_irq_inh;
  logic w_n, w_v, w_d, w_i, w_z, w_c;
  logic w_alu_zero;
  logic w_bus_zero;

  assign w_alu_zero = (sif.alu_result == 8'h00);
  assign w_bus_zero = (sif.bus_in == 8'h00);

  // Next-state selection: every flag holds unless the active command names it
  always_comb begin
    w_n = r_n;
    w_v = r_v;
    w_d = r_d;
    w_i = r_i;
    w_z = r_z;
    w_c = r_c;
    if (sif.flag_en) begin
      case (sif.flag_op)
        FOP_NZ: begin
          w_n = sif.alu_result[7];
          w_z = w_alu_zero;
        end
        FOP_NZC: begin
          w_n = sif.alu_result[7];
          w_z = w_alu_zero;
          w_c = sif.alu_carry;
        end
        FOP_NZCV: begin
          w_n = sif.alu_result[7];
          w_z = w_alu_zero;
          w_c = sif.alu_carry;
          w_v = sif.alu_overflow;
        end
        FOP_NZ_BUS: begin
          w_n = sif.bus_in[7];
          w_z = w_bus_zero;
        end
        FOP_BIT: begin
          // N and V come from the memory operand, Z from A AND M
          w_n = sif.bus_in[7];
          w_v = sif.bus_in[6];
          w_z = w_alu_zero;
        end
        FOP_PLP: begin
          // bits 5 and 4 of the pulled byte have no storage and are dropped
          w_n = sif.bus_in[P_N];
          w_v = sif.bus_in[P_V];
          w_d = sif.bus_in[P_D];
          w_i = sif.bus_in[P_I];
          w_z = sif.bus_in[P_Z];
          w_c = sif.bus_in[P_C];
        end
        FOP_CLC:       w_c = 1'b0;
        FOP_SEC:       w_c = 1'b1;
        FOP_CLI:       w_i = 1'b0;
        FOP_SEI:       w_i = 1'b1;
        FOP_CLD:       w_d = 1'b0;
        FOP_SED:       w_d = 1'b1;
        FOP_CLV:       w_v = 1'b0;
        FOP_IRQ_ENTRY: w_i = 1'b1;
        default: ;     // NOP and the reserved code leave all flags alone
      endcase
    end
  end

  // Flag storage; reset is asynchronous and overrides any command in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n <= 1'b0;
      r_v <= 1'b0;
      r_d <= RESET_D;
      r_i <= RESET_I;
      r_z <= 1'b0;
      r_c <= 1'b0;
    end else begin
      r_n <= w_n;
      r_v <= w_v;
      r_d <= w_d;
      r_i <= w_i;
      r_z <= w_z;
      r_c <= w_c;
    end
  end

  // Interrupt inhibit follows I one clock later, regardless of flag_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq_inh <= RESET_I;
    else     r_irq_inh <= r_i;
  end

  assign sif.p_out         = make_p(r_n, r_v, sif.push_brk, r_d, r_i, r_z, r_c);
  assign sif.carry_flag    = r_c;
  assign sif.decimal_flag  = r_d;
  assign sif.zero_flag     = r_z;
  assign sif.negative_flag = r_n;
  assign sif.overflow_flag = r_v;
  assign sif.irq_inhibit   = r_irq_inh;

endmodule
`default_nettype wire

// File: tb/tb_status_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_status_reg
// Purpose  : Self-checking bench for status_reg: directed scenarios with
//            hand-derived P values plus randomized commands against a
//            byte-level reference model of the P register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_status_reg;
  import status_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  // Reference state: P byte with bit 5 = 1 and bit 4 = 0, plus delayed I
  logic [7:0] m_p;
  logic       m_inh;

  status_reg_if sif();

  status_reg #(.RESET_I(1'b1), .RESET_D(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: what P becomes after one enabled/disabled command
  function automatic logic [7:0] model_next(input logic [7:0] p, input logic en,
                                            input logic [3:0] op, input logic [7:0] alu,
                                            input logic c, input logic v,
                                            input logic [7:0] bus);
    logic [7:0] r;
    r = p;
    if (en) begin
      case (op)
        4'd1, 4'd2, 4'd3: begin
          r[P_N] = alu[7];
          r[P_Z] = (alu == 8'd0);
          if (op >= 4'd2) r[P_C] = c;
          if (op == 4'd3) r[P_V] = v;
        end
        4'd4: begin r[P_N] = bus[7]; r[P_Z] = (bus == 8'd0); end
        4'd5: begin r[P_N] = bus[7]; r[P_V] = bus[6]; r[P_Z] = (alu == 8'd0); end
        4'd6: r = (bus & 8'hCF) | 8'h20;
        4'd7:  r[P_C] = 1'b0;
        4'd8:  r[P_C] = 1'b1;
        4'd9:  r[P_I] = 1'b0;
        4'd10: r[P_I] = 1'b1;
        4'd11: r[P_D] = 1'b0;
        4'd12: r[P_D] = 1'b1;
        4'd13: r[P_V] = 1'b0;
        4'd14: r[P_I] = 1'b1;
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] exp_p;
    exp_p = m_p | {3'b000, sif.push_brk, 4'b0000};
    check({tag, ".p_out"}, sif.p_out, exp_p);
    check({tag, ".carry"}, {7'd0, sif.carry_flag}, {7'd0, m_p[P_C]});
    check({tag, ".decimal"}, {7'd0, sif.decimal_flag}, {7'd0, m_p[P_D]});
    check({tag, ".zero"}, {7'd0, sif.zero_flag}, {7'd0, m_p[P_Z]});
    check({tag, ".neg"}, {7'd0, sif.negative_flag}, {7'd0, m_p[P_N]});
    check({tag, ".ovf"}, {7'd0, sif.overflow_flag}, {7'd0, m_p[P_V]});
    check({tag, ".irq_inh"}, {7'd0, sif.irq_inhibit}, {7'd0, m_inh});
  endtask

  // Drive one command, clock it in, advance the model, compare everything
  task automatic step(input string tag, input logic en, input logic [3:0] op,
                      input logic [7:0] alu, input logic c, input logic v,
                      input logic [7:0] bus, input logic pb);
    sif.flag_en      = en;
    sif.flag_op      = flag_op_e'(op);
    sif.alu_result   = alu;
    sif.alu_carry    = c;
    sif.alu_overflow = v;
    sif.bus_in       = bus;
    sif.push_brk     = pb;
    @(posedge clk);
    #1;
    m_inh = m_p[P_I];
    m_p   = model_next(m_p, en, op, alu, c, v, bus);
    check_all(tag);
  endtask

  // Directed step with an additional hand-derived P and irq_inhibit value
  task automatic dstep(input string tag, input logic en, input logic [3:0] op,
                       input logic [7:0] alu, input logic c, input logic v,
                       input logic [7:0] bus, input logic [7:0] exp_p,
                       input logic exp_inh);
    step(tag, en, op, alu, c, v, bus, 1'b0);
    check({tag, ".const_p"}, sif.p_out, exp_p);
    check({tag, ".const_inh"}, {7'd0, sif.irq_inhibit}, {7'd0, exp_inh});
  endtask

  // Pulse reset between edges and verify the outputs react without a clock
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    m_p   = P_RESET;
    m_inh = 1'b1;
    check_all(tag);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    sif.flag_en = 1'b0;
    sif.flag_op = FOP_NOP;
    sif.alu_result = 8'h00;
    sif.alu_carry = 1'b0;
    sif.alu_overflow = 1'b0;
    sif.bus_in = 8'h00;
    sif.push_brk = 1'b0;
    m_p   = P_RESET;
    m_inh = 1'b1;

    #12;
    check_all("reset");
    check("reset.const_p", sif.p_out, 8'h24);
    rst = 1'b0;

    // Load every flag, then reset asynchronously mid-cycle
    dstep("plp_ff_pre", 1, 4'd6, 8'h00, 0, 0, 8'hFF, 8'hEF, 1'b1);
    async_reset("rst_async");
    check("rst_async.const_p", sif.p_out, 8'h24);

    // Arithmetic flags at the 0x00 / 0x80 boundaries
    dstep("nzcv_00", 1, 4'd3, 8'h00, 1, 1, 8'h00, 8'h67, 1'b1);
    dstep("nzcv_80", 1, 4'd3, 8'h80, 0, 0, 8'h00, 8'hA4, 1'b1);
    dstep("nz_bus_00", 1, 4'd4, 8'h00, 0, 0, 8'h00, 8'h26, 1'b1);
    dstep("nz_bus_80", 1, 4'd4, 8'h00, 0, 0, 8'h80, 8'hA4, 1'b1);

    // Pull and push views of P
    dstep("plp_ff", 1, 4'd6, 8'h00, 0, 0, 8'hFF, 8'hEF, 1'b1);
    sif.push_brk = 1'b1;
    #1;
    check("push_brk1", sif.p_out, 8'hFF);
    sif.push_brk = 1'b0;
    dstep("plp_00", 1, 4'd6, 8'h00, 0, 0, 8'h00, 8'h20, 1'b1);
    dstep("inh_follow", 1, 4'd0, 8'h00, 0, 0, 8'h00, 8'h20, 1'b0);

    // BIT leaves C alone
    dstep("sec", 1, 4'd8, 8'h00, 0, 0, 8'h00, 8'h21, 1'b0);
    dstep("bit_z1", 1, 4'd5, 8'h00, 0, 0, 8'hC0, 8'hE3, 1'b0);
    dstep("bit_z0", 1, 4'd5, 8'h01, 0, 0, 8'hC0, 8'hE1, 1'b0);

    // I to irq_inhibit latency
    dstep("sei0", 1, 4'd10, 8'h00, 0, 0, 8'h00, 8'hE5, 1'b0);
    dstep("sei0_lag", 1, 4'd0, 8'h00, 0, 0, 8'h00, 8'hE5, 1'b1);
    dstep("cli_k", 1, 4'd9, 8'h00, 0, 0, 8'h00, 8'hE1, 1'b1);
    dstep("sei_k1", 1, 4'd10, 8'h00, 0, 0, 8'h00, 8'hE5, 1'b0);
    dstep("sei_lag", 1, 4'd0, 8'h00, 0, 0, 8'h00, 8'hE5, 1'b1);

    // Hold, reserved, back-to-back, then reset mid-sequence
    dstep("clc", 1, 4'd7, 8'h00, 0, 0, 8'h00, 8'hE4, 1'b1);
    dstep("hold_en0", 0, 4'd8, 8'h00, 1, 1, 8'hFF, 8'hE4, 1'b1);
    dstep("reserved", 1, 4'd15, 8'h00, 1, 1, 8'hFF, 8'hE4, 1'b1);
    dstep("sec_b2b", 1, 4'd8, 8'h00, 0, 0, 8'h00, 8'hE5, 1'b1);
    dstep("clc_b2b", 1, 4'd7, 8'h00, 0, 0, 8'h00, 8'hE4, 1'b1);
    dstep("sed", 1, 4'd12, 8'h00, 0, 0, 8'h00, 8'hEC, 1'b1);
    dstep("cli", 1, 4'd9, 8'h00, 0, 0, 8'h00, 8'hE8, 1'b1);
    dstep("sec_mid", 1, 4'd8, 8'h00, 0, 0, 8'h00, 8'hE9, 1'b0);
    async_reset("rst_mid");
    check("rst_mid.const_p", sif.p_out, 8'h24);

    // Randomized commands against the model
    for (int n = 0; n < 500; n++) begin
      logic       en;
      logic [3:0] op;
      logic [7:0] alu;
      logic [7:0] bus;
      int         pick;
      en   = ($urandom_range(0, 3) != 0);
      op   = 4'($urandom_range(0, 15));
      pick = $urandom_range(0, 3);
      alu  = (pick == 0) ? 8'h00 : (pick == 1) ? 8'h80 : 8'($urandom);
      pick = $urandom_range(0, 3);
      bus  = (pick == 0) ? 8'h00 : (pick == 1) ? 8'h80 : 8'($urandom);
      step("rand", en, op, alu, 1'($urandom), 1'($urandom), bus, 1'($urandom));
      if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/status_reg.md
Name: status_reg

Overview:
- 6502 processor status register (P), placed directly downstream of the ALU.
- Consumes the ALU result byte, carry-out and overflow, and updates the N, V, D, I, Z and C flags under a one-op-per-cycle flag command.
- Feeds the carry and decimal flags back to the ALU inputs, and supplies flags to the branch logic.
- Supplies the pushable P byte for PHP/BRK/IRQ and a one-cycle-delayed interrupt inhibit to the interrupt logic.

Parameters:
- RESET_I, 1, value of the I flag after reset.
- RESET_D, 0, value of the D flag after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flag_en  in  1  when high, flag_op takes effect at this rising edge.
- flag_op  in  4  flag command (encoding below).
- alu_result  in  8  ALU hold register value.
- alu_carry  in  1  ALU carry_out.
- alu_overflow  in  1  ALU overflow.
- bus_in  in  8  data bus byte (PLP/RTI pull, BIT operand, load value).
- push_brk  in  1  B bit value placed in p_out (1 for PHP/BRK, 0 for IRQ/NMI).
- p_out  out  8  {N,V,1,push_brk,D,I,Z,C}, combinational from the stored flags.
- carry_flag  out  1  C; drives ALU carry_in.
- decimal_flag  out  1  D; drives ALU decimal_mode.
- zero_flag  out  1  Z.
- negative_flag  out  1  N.
- overflow_flag  out  1  V.
- irq_inhibit  out  1  registered copy of I, delayed one cycle.

Behaviour:
- Storage is six flops: N, V, D, I, Z, C. Bit 5 of p_out is constant 1. B is not stored.
- Reset, asynchronous, dominates everything, including a reset asserted mid-op:
  - N=V=Z=C=0, D=RESET_D, I=RESET_I.
  - irq_inhibit=RESET_I.
- flag_en=0: all six flags hold; flag_op is ignored.
- flag_en=1: exactly one op applies at the rising edge; new values are visible on the outputs after that edge (1-cycle latency). Flags not named by the op hold.
- flag_op encoding:
  - 0 NOP: no change.
  - 1 NZ: N=alu_result[7]; Z=(alu_result==0).
  - 2 NZC: as NZ, plus C=alu_carry (ASL/LSR/CMP/CPX/CPY).
  - 3 NZCV: as NZC, plus V=alu_overflow (ADC/SBC).
  - 4 NZ_BUS: N=bus_in[7]; Z=(bus_in==0) (LDA/LDX/LDY/PLA/TAX…).
  - 5 BIT: N=bus_in[7]; V=bus_in[6]; Z=(alu_result==0). Here alu_result is A AND M.
  - 6 PLP: N,V,D,I,Z,C loaded from bus_in bits 7,6,3,2,1,0. Bits 5 and 4 are discarded.
  - 7 CLC: C=0.
  - 8 SEC: C=1.
  - 9 CLI: I=0.
  - 10 SEI: I=1.
  - 11 CLD: D=0.
  - 12 SED: D=1.
  - 13 CLV: V=0.
  - 14 IRQ_ENTRY: I=1; all other flags hold.
  - 15 reserved: treated as NOP.
- Z is computed on the full 8 bits. Values of 0x00 and 0x80 must both be checked.
- irq_inhibit: flop, irq_inhibit <= I every clock, independent of flag_en.
  - After CLI/SEI/PLP changes I at edge k, irq_inhibit follows at edge k+1.
  - This models the 6502 one-instruction CLI/SEI latency.
- p_out reflects the stored flags in the same cycle, with B taken live from push_brk. No registering.
- Back-to-back ops on consecutive cycles are legal. Each op sees the flags as left by the previous edge.
- decimal_flag is exported only; BCD correction is not done here.

Decomposition:
- Shared package status_pkg:
  - flag_op enum (4-bit values above).
  - Bit-position constants P_N=7, P_V=6, P_U=5, P_B=4, P_D=3, P_I=2, P_Z=1, P_C=0.
  - Reset-value constant for P.
- The ALU and the future control unit import status_pkg.
- No sub-module; the block is a single flat register with next-state logic.

Test Plan:
- Reset: assert rst asynchronously between edges -> outputs change immediately; p_out=0x24 with push_brk=0; irq_inhibit=1, carry_flag=0, decimal_flag=0.
- NZCV: flag_op=3, alu_result=0x00, alu_carry=1, alu_overflow=1 -> next cycle Z=1, N=0, C=1, V=1. Then alu_result=0x80, carry=0, overflow=0 -> N=1, Z=0, C=0, V=0.
- PLP/push: flag_op=6, bus_in=0xFF -> p_out=0xEF with push_brk=0 and 0xFF with push_brk=1. Then bus_in=0x00 -> p_out=0x20 with push_brk=0.
- BIT: bus_in=0xC0, alu_result=0x00, flag_op=5 -> N=1, V=1, Z=1, C unchanged. Repeat with alu_result=0x01 -> Z=0.
- I latency: from I=1, CLI at edge k -> I=0 after edge k, irq_inhibit=0 only after edge k+1. SEI on the next cycle -> irq_inhibit returns to 1 one edge after I.
- Hold/reserved: flag_en=0 with flag_op=8 (SEC), then flag_en=1 with flag_op=15 -> no flag changes. Then SEC, CLC on consecutive cycles -> C goes 1 then 0; rst asserted mid-sequence -> C=0, I=1 immediately.
